// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: frames scan codes and emits 9-bit make/break events.
// Optional odd-parity enforcement when PS2_PARITY_CHK_EN is defined.
`timescale 1ns/1ps
module ps2_kbd_rx #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       full,
  output logic [8:0] dout,
  output logic       wr,
  output logic       err,
  output logic       ovf
);

  localparam int FW = $clog2(FILT_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  logic [1:0]    ck_s_q, dt_s_q;
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  state_t        st_q;
  logic [2:0]    bcnt_q;
  logic [7:0]    sh_q;
  logic          par_q;
  logic          rel_q;
  logic [TW-1:0] to_q;
  logic [8:0]    dout_q;
  logic          wr_q, err_q, ovf_q;

  logic          samp_d, bit_d, par_ok_d, frame_ok_d;
  logic [8:0]    ev_d;

  assign bit_d  = dt_s_q[1];
  assign samp_d = filt_q && !ck_s_q[1]
               && (fcnt_q == FW'(FILT_LEN - 1));

`ifdef PS2_PARITY_CHK_EN
  assign par_ok_d = ^{sh_q, par_q};
`else
  // parity bit is captured but not enforced
  assign par_ok_d = par_q | 1'b1;
`endif

  assign frame_ok_d = bit_d && par_ok_d;
  assign ev_d       = {rel_q, sh_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      ck_s_q <= 2'b11;
      dt_s_q <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      st_q   <= IDLE;
      bcnt_q <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      rel_q  <= 1'b0;
      to_q   <= '0;
      dout_q <= '0;
      wr_q   <= 1'b0;
      err_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      ck_s_q <= {ck_s_q[0], ps2_clk};
      dt_s_q <= {dt_s_q[0], ps2_data};
      wr_q   <= 1'b0;
      err_q  <= 1'b0;

      if (ck_s_q[1] != filt_q) begin
        if (fcnt_q == FW'(FILT_LEN - 1)) begin
          filt_q <= ck_s_q[1];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 1'b1;
        end
      end else begin
        fcnt_q <= '0;
      end

      if (samp_d) begin
        to_q <= '0;
        unique case (st_q)
          IDLE: begin
            if (!bit_d) begin
              st_q   <= DATA;
              bcnt_q <= '0;
              sh_q   <= '0;
            end else begin
              err_q  <= 1'b1;
            end
          end
          DATA: begin
            sh_q   <= {bit_d, sh_q[7:1]};
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == 3'd7) st_q <= PAR;
          end
          PAR: begin
            par_q <= bit_d;
            st_q  <= STOP;
          end
          STOP: begin
            st_q <= IDLE;
            if (!frame_ok_d) begin
              err_q <= 1'b1;
            end else if (sh_q == 8'hF0) begin
              rel_q <= 1'b1;
            end else if (sh_q != 8'hE0) begin
              rel_q <= 1'b0;
              if (full) begin
                ovf_q  <= 1'b1;
              end else begin
                wr_q   <= 1'b1;
                dout_q <= ev_d;
              end
            end
          end
        endcase
      end else if (st_q != IDLE) begin
        // no clock edge for too long: drop the partial frame
        if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          st_q  <= IDLE;
          err_q <= 1'b1;
          sh_q  <= '0;
          to_q  <= '0;
        end else begin
          to_q  <= to_q + 1'b1;
        end
      end
    end
  end

  assign dout = dout_q;
  assign wr   = wr_q;
  assign err  = err_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed frames against a
// byte-level make/break model, checked every cycle.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int TO = 50000;
  localparam int H  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       full = 1'b0;
  logic [8:0] dout;
  logic       wr, err, ovf;

  int checks = 0;
  int fails  = 0;

  logic [8:0] exp_q[$];
  logic [8:0] last_dout = '0;
  logic       m_rel = 1'b0;
  logic       m_ovf = 1'b0;
  int         err_exp = 0;
  int         err_seen = 0;
  logic       prev_wr = 1'b0;
  logic       prev_ovf = 1'b0;

  ps2_kbd_rx #(.TIMEOUT_CYC(TO), .FILT_LEN(8)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .full(full), .dout(dout), .wr(wr), .err(err), .ovf(ovf)
  );

  always #10 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      prev_wr   = 1'b0;
      prev_ovf  = 1'b0;
      last_dout = '0;
      err_seen  = 0;
    end else begin
      if (wr) begin
        check("wr_gap", {31'b0, prev_wr}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexp_wr", {31'b0, wr}, 32'd0);
        end else begin
          last_dout = exp_q.pop_front();
          check("dout_ev", {23'b0, dout}, {23'b0, last_dout});
        end
      end else begin
        check("dout_hold", {23'b0, dout}, {23'b0, last_dout});
      end
      if (prev_ovf) check("ovf_sticky", {31'b0, ovf}, 32'd1);
      if (err) err_seen++;
      prev_wr  = wr;
      prev_ovf = ovf;
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(logic [10:0] bits, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ps2_data = bits[i];
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic model(logic [7:0] b, logic bad);
`ifdef PS2_PARITY_CHK_EN
    if (bad) begin
      err_exp++;
      return;
    end
`endif
    if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b != 8'hE0) begin
      if (full) m_ovf = 1'b1;
      else exp_q.push_back({m_rel, b});
      m_rel = 1'b0;
    end
  endtask

  task automatic send_byte(logic [7:0] b, logic bad);
    logic par;
    par = ~(^b) ^ bad;
    model(b, bad);
    send_bits({1'b1, par, b, 1'b0}, 11);
    tick(20);
  endtask

  task automatic phase(string name);
    @(negedge clk);
    check({name, "_drain"}, exp_q.size(), 32'd0);
    check({name, "_err"}, err_seen, err_exp);
    check({name, "_ovf"}, {31'b0, ovf}, {31'b0, m_ovf});
  endtask

  task automatic do_reset();
    @(posedge clk);
    rst = 1'b0;
    tick(2);
    exp_q.delete();
    m_rel   = 1'b0;
    m_ovf   = 1'b0;
    err_exp = 0;
    @(posedge clk);
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_dout", {23'b0, dout}, 32'h000);
    check("rst_wr", {31'b0, wr}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);

    send_byte(8'h1D, 1'b0);
    phase("t1");
    check("t1_dout", {23'b0, dout}, 32'h01D);

    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    phase("t2a");
    check("t2_brk", {23'b0, dout}, 32'h11D);
    send_byte(8'h1D, 1'b0);
    phase("t2b");
    check("t2_mk", {23'b0, dout}, 32'h01D);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    phase("t3a");
    check("t3_ext_mk", {23'b0, dout}, 32'h075);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    phase("t3b");
    check("t3_ext_brk", {23'b0, dout}, 32'h175);

    full = 1'b1;
    send_byte(8'h1C, 1'b0);
    phase("t4a");
    check("t4_ovf", {31'b0, ovf}, 32'd1);
    check("t4_hold", {23'b0, dout}, 32'h175);
    full = 1'b0;
    send_byte(8'h1B, 1'b0);
    phase("t4b");
    check("t4_dout", {23'b0, dout}, 32'h01B);
    check("t4_ovf2", {31'b0, ovf}, 32'd1);

    send_bits(11'b000_0001_0110, 5);
    err_exp++;
    tick(TO + 200);
    phase("t5a");
    send_byte(8'h23, 1'b0);
    phase("t5b");
    check("t5_dout", {23'b0, dout}, 32'h023);

    send_byte(8'h1D, 1'b1);
    phase("t6");
`ifdef PS2_PARITY_CHK_EN
    check("t6_dout", {23'b0, dout}, 32'h023);
`else
    check("t6_dout", {23'b0, dout}, 32'h01D);
`endif

    send_bits(11'b000_0000_1100, 4);
    do_reset();
    tick(4);
    send_byte(8'h1C, 1'b0);
    phase("t7");
    check("t7_dout", {23'b0, dout}, 32'h01C);
    check("t7_ovf", {31'b0, ovf}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
